flos_cfs_responder: RTL and testbench



---
 rtl/flos_cfs_pkg.sv | 30 +++
 rtl/flos_evt_fifo.sv | 53 +++++
 rtl/flos_cfs_responder.sv | 170 +++++++++++++++++
 tb/tb_flos_cfs_responder.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/flos_cfs_pkg.sv
// Shared constants for the FLOS CFS responder: register indices, bit positions, response codes.
package flos_cfs_pkg;

    // Register index = bus_addr[4:2]
    localparam logic [2:0] RegCtrl   = 3'd0;
    localparam logic [2:0] RegStatus = 3'd1;
    localparam logic [2:0] RegPush   = 3'd2;
    localparam logic [2:0] RegResult = 3'd3;
    localparam logic [2:0] RegRescnt = 3'd4;

    localparam int unsigned CtrlEnBit    = 0;
    localparam int unsigned CtrlClrBit   = 1;
    localparam int unsigned CtrlIrqEnBit = 2;

    localparam int unsigned StEmptyBit = 0;
    localparam int unsigned StFullBit  = 1;
    localparam int unsigned StLevelLsb = 8;
    localparam int unsigned StLevelW   = 7;
    localparam int unsigned StOvfBit   = 16;
    localparam int unsigned StPendBit  = 17;

    localparam int unsigned RescntW = 16;

    typedef enum logic [1:0] {
        RespNone = 2'b00,
        RespAck  = 2'b01,
        RespErr  = 2'b10
    } resp_e;

endpackage

// File: rtl/flos_evt_fifo.sv
// Synchronous event FIFO with clear; head reads 0 while empty.
module flos_evt_fifo #(
    parameter int unsigned Depth = 8,
    parameter int unsigned DataW = 32,
    localparam int unsigned PtrW = $clog2(Depth),
    localparam int unsigned LvlW = PtrW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [DataW-1:0] push_data,
    input  logic             pop,
    input  logic             clear,
    output logic [DataW-1:0] head,
    output logic             empty,
    output logic             full,
    output logic [LvlW-1:0]  level
);

    logic [DataW-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [LvlW-1:0]  level_q;
    logic             do_push, do_pop;

    assign empty   = (level_q == '0);
    assign full    = (level_q == LvlW'(Depth));
    assign level   = level_q;
    assign do_push = push & ~full & ~clear;
    assign do_pop  = pop & ~empty & ~clear;
    assign head    = empty ? '0 : mem_q[rd_ptr_q];

    // Depth is a power of two, so pointers wrap by natural overflow
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            level_q <= level_q + LvlW'(do_push) - LvlW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
        end else if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/flos_cfs_responder.sv
// CFS register window for the FLOS accelerator: bus decode, control/status, event FIFO, results.
module flos_cfs_responder
    import flos_cfs_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned ADDR_W     = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              bus_stb_i,
    input  logic              bus_rw_i,
    input  logic [ADDR_W-1:0] bus_addr_i,
    input  logic [DATA_W-1:0] bus_data_i,
    input  logic [3:0]        bus_ben_i,
    output logic [DATA_W-1:0] bus_data_o,
    output logic              bus_ack_o,
    output logic              bus_err_o,
    output logic              evt_valid_o,
    output logic [DATA_W-1:0] evt_data_o,
    input  logic              evt_ready_i,
    input  logic              res_valid_i,
    input  logic [DATA_W-1:0] res_data_i,
    output logic              irq_o
);

    localparam int unsigned LvlW = $clog2(FIFO_DEPTH) + 1;

    logic               enable_q, enable_d, irq_en_q, irq_en_d;
    logic               ovf_q, ovf_d, pend_q, pend_d, irq_q;
    logic [DATA_W-1:0]  result_q, result_d, rdata_q, rdata_d;
    logic [RescntW-1:0] rescnt_q, rescnt_d;
    resp_e              resp_q, resp_d;

    logic              fifo_push, fifo_pop, fifo_clear, fifo_empty, fifo_full;
    logic [LvlW-1:0]   fifo_level;
    logic [DATA_W-1:0] fifo_head;
    logic [2:0]        reg_idx;
    logic [31:0]       status_word, ctrl_word;
    logic              unused_addr;

    assign reg_idx     = bus_addr_i[4:2];
    assign unused_addr = ^{bus_addr_i[ADDR_W-1:5], bus_addr_i[1:0]};
    assign fifo_pop    = evt_valid_o & evt_ready_i;

    flos_evt_fifo #(
        .Depth (FIFO_DEPTH),
        .DataW (DATA_W)
    ) u_fifo (
        .clk       (clk_i),
        .rst       (rst_i),
        .push      (fifo_push),
        .push_data (bus_data_i),
        .pop       (fifo_pop),
        .clear     (fifo_clear),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .level     (fifo_level)
    );

    always_comb begin
        status_word = '0;
        status_word[StEmptyBit] = fifo_empty;
        status_word[StFullBit]  = fifo_full;
        status_word[StLevelLsb +: StLevelW] = StLevelW'(fifo_level);
        status_word[StOvfBit]   = ovf_q;
        status_word[StPendBit]  = pend_q;
        ctrl_word = '0;
        ctrl_word[CtrlEnBit]    = enable_q;
        ctrl_word[CtrlIrqEnBit] = irq_en_q;
    end

    always_comb begin
        resp_d     = RespNone;
        rdata_d    = '0;
        fifo_push  = 1'b0;
        fifo_clear = 1'b0;
        enable_d   = enable_q;
        irq_en_d   = irq_en_q;
        ovf_d      = ovf_q;
        pend_d     = pend_q;
        result_d   = result_q;
        rescnt_d   = rescnt_q;

        if (bus_stb_i) begin
            resp_d = RespAck;
            case (reg_idx)
                RegCtrl: begin
                    if (!bus_rw_i) begin
                        rdata_d = DATA_W'(ctrl_word);
                    end else if (bus_ben_i[0]) begin
                        enable_d   = bus_data_i[CtrlEnBit];
                        irq_en_d   = bus_data_i[CtrlIrqEnBit];
                        fifo_clear = bus_data_i[CtrlClrBit];
                    end
                end
                RegStatus: begin
                    if (!bus_rw_i) begin
                        rdata_d = DATA_W'(status_word);
                    end else if (bus_data_i[StOvfBit]) begin
                        ovf_d = 1'b0;
                    end
                end
                RegPush: begin
                    if (bus_rw_i) begin
                        // Full is judged on registered state; a same-cycle pop does not help
                        if (bus_ben_i != 4'hF) begin
                            resp_d = RespErr;
                        end else if (fifo_full) begin
                            resp_d = RespErr;
                            ovf_d  = 1'b1;
                        end else begin
                            fifo_push = 1'b1;
                        end
                    end
                end
                RegResult: begin
                    if (!bus_rw_i) begin
                        rdata_d = result_q;
                        pend_d  = 1'b0;
                    end
                end
                RegRescnt: begin
                    if (!bus_rw_i) rdata_d = DATA_W'(rescnt_q);
                end
                default: resp_d = RespErr;
            endcase
        end

        // A new result overrides a same-cycle RESULT read clearing pending
        if (res_valid_i) begin
            result_d = res_data_i;
            rescnt_d = rescnt_q + RescntW'(1);
            pend_d   = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            enable_q <= 1'b0;
            irq_en_q <= 1'b0;
            ovf_q    <= 1'b0;
            pend_q   <= 1'b0;
            irq_q    <= 1'b0;
            result_q <= '0;
            rescnt_q <= '0;
            rdata_q  <= '0;
            resp_q   <= RespNone;
        end else begin
            enable_q <= enable_d;
            irq_en_q <= irq_en_d;
            ovf_q    <= ovf_d;
            pend_q   <= pend_d;
            irq_q    <= irq_en_q & pend_q;
            result_q <= result_d;
            rescnt_q <= rescnt_d;
            rdata_q  <= rdata_d;
            resp_q   <= resp_d;
        end
    end

    assign bus_ack_o   = (resp_q == RespAck);
    assign bus_err_o   = (resp_q == RespErr);
    assign bus_data_o  = rdata_q;
    assign evt_valid_o = enable_q & ~fifo_empty;
    assign evt_data_o  = fifo_head;
    assign irq_o       = irq_q;

endmodule

// File: tb/tb_flos_cfs_responder.sv
// Self-checking bench for flos_cfs_responder: queue-based reference model plus directed literals.
module tb_flos_cfs_responder;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stb = 1'b0, rw = 1'b0, ready = 1'b0, res_valid = 1'b0;
    logic [7:0]  addr = '0;
    logic [31:0] wdata = '0, res_data = '0;
    logic [3:0]  ben = '0;

    logic [31:0] bus_data_o, evt_data_o;
    logic        bus_ack_o, bus_err_o, evt_valid_o, irq_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    flos_cfs_responder dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .bus_stb_i   (stb),
        .bus_rw_i    (rw),
        .bus_addr_i  (addr),
        .bus_data_i  (wdata),
        .bus_ben_i   (ben),
        .bus_data_o  (bus_data_o),
        .bus_ack_o   (bus_ack_o),
        .bus_err_o   (bus_err_o),
        .evt_valid_o (evt_valid_o),
        .evt_data_o  (evt_data_o),
        .evt_ready_i (ready),
        .res_valid_i (res_valid),
        .res_data_i  (res_data),
        .irq_o       (irq_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: state as it stands after the most recent clock edge
    logic [31:0] q[$];
    bit          m_valid = 0, m_rst_seen = 0;
    bit          m_en, m_ie, m_ovf, m_pend, m_irq, m_ack, m_err;
    logic [31:0] m_res, m_rdata;
    logic [15:0] m_cnt;

    always @(posedge clk) begin : model
        bit          n_en, n_ie, n_ovf, n_pend, n_ack, n_err, do_push, do_clear, do_pop, was_full;
        logic [31:0] n_rdata, n_res;
        logic [15:0] n_cnt;
        int          lvl;
        if (rst) begin
            q.delete();
            m_en = 0; m_ie = 0; m_ovf = 0; m_pend = 0; m_irq = 0; m_ack = 0; m_err = 0;
            m_res = '0; m_rdata = '0; m_cnt = '0;
            m_valid = 1; m_rst_seen = 1;
        end else begin
            m_rst_seen = 0;
            lvl = q.size();
            was_full = (lvl == DEPTH);
            n_en = m_en; n_ie = m_ie; n_ovf = m_ovf; n_pend = m_pend;
            n_res = m_res; n_cnt = m_cnt;
            n_ack = 0; n_err = 0; n_rdata = '0; do_push = 0; do_clear = 0;
            do_pop = m_en && lvl > 0 && ready;
            if (stb) begin
                case (addr[4:2])
                    3'd0: begin
                        n_ack = 1;
                        if (!rw) n_rdata = 32'(m_en) | (32'(m_ie) << 2);
                        else if (ben[0]) begin
                            n_en = wdata[0]; n_ie = wdata[2]; do_clear = wdata[1];
                        end
                    end
                    3'd1: begin
                        n_ack = 1;
                        if (!rw) n_rdata = 32'(lvl == 0) | (32'(was_full) << 1) | (32'(lvl) << 8)
                                         | (32'(m_ovf) << 16) | (32'(m_pend) << 17);
                        else if (wdata[16]) n_ovf = 0;
                    end
                    3'd2: begin
                        if (!rw) n_ack = 1;
                        else if (ben != 4'hF) n_err = 1;
                        else if (was_full) begin n_err = 1; n_ovf = 1; end
                        else begin n_ack = 1; do_push = 1; end
                    end
                    3'd3: begin
                        n_ack = 1;
                        if (!rw) begin n_rdata = m_res; n_pend = 0; end
                    end
                    3'd4: begin
                        n_ack = 1;
                        if (!rw) n_rdata = 32'(m_cnt);
                    end
                    default: n_err = 1;
                endcase
            end
            if (res_valid) begin
                n_res = res_data; n_cnt = m_cnt + 16'd1; n_pend = 1;
            end
            m_irq = m_ie && m_pend;
            if (do_clear) q.delete();
            else begin
                if (do_pop) void'(q.pop_front());
                if (do_push) q.push_back(wdata);
            end
            m_en = n_en; m_ie = n_ie; m_ovf = n_ovf; m_pend = n_pend;
            m_res = n_res; m_cnt = n_cnt; m_ack = n_ack; m_err = n_err; m_rdata = n_rdata;
        end
    end

    always @(negedge clk) begin : compare
        bit exp_valid;
        if (m_valid) begin
            exp_valid = m_en && q.size() > 0;
            chk("m_ack", bus_ack_o, m_ack);
            chk("m_err", bus_err_o, m_err);
            chk("m_rdata", bus_data_o, m_rdata);
            chk("m_evt_valid", evt_valid_o, exp_valid);
            if (exp_valid) chk("m_evt_data", evt_data_o, q[0]);
            if (m_rst_seen) chk("m_evt_data_rst", evt_data_o, 32'h0);
            chk("m_irq", irq_o, m_irq);
        end
    end

    // Caller is at posedge+1; returns at posedge+1 after sampling the response
    task automatic access(input logic w, input logic [7:0] a, input logic [31:0] d,
                          input logic [3:0] be, output logic ack, output logic err,
                          output logic [31:0] rd);
        stb = 1; rw = w; addr = a; wdata = d; ben = be;
        @(posedge clk); #1;
        stb = 0; rw = 0; wdata = '0;
        @(negedge clk);
        ack = bus_ack_o; err = bus_err_o; rd = bus_data_o;
        @(posedge clk); #1;
    endtask

    task automatic rd_expect(input string name, input logic [7:0] a, input logic [31:0] exp);
        logic ack, err;
        logic [31:0] rd;
        access(1'b0, a, '0, 4'hF, ack, err, rd);
        chk({name, "_ack"}, ack, 1);
        chk(name, rd, exp);
    endtask

    task automatic wr_expect(input string name, input logic [7:0] a, input logic [31:0] d,
                             input logic [3:0] be, input logic exp_err);
        logic ack, err;
        logic [31:0] rd;
        access(1'b1, a, d, be, ack, err, rd);
        chk({name, "_ack"}, ack, !exp_err);
        chk({name, "_err"}, err, exp_err);
    endtask

    initial begin
        logic ack, err;
        logic [31:0] rd;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ack", bus_ack_o, 0);
        chk("rst_valid", evt_valid_o, 0);
        chk("rst_irq", irq_o, 0);
        @(posedge clk); #1;
        rst = 0;

        rd_expect("status_after_rst", 8'h04, 32'h0000_0001);

        wr_expect("ctrl_en", 8'h00, 32'h1, 4'hF, 0);
        for (int i = 0; i < DEPTH; i++)
            wr_expect("push", 8'h08, 32'hA5A5_0001 + i, 4'hF, 0);
        rd_expect("status_full", 8'h04, 32'h0000_0802);
        wr_expect("push_overflow", 8'h08, 32'hDEAD_0009, 4'hF, 1);
        rd_expect("status_ovf", 8'h04, 32'h0001_0802);
        chk("head_kept", evt_data_o, 32'hA5A5_0001);

        ready = 1;
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            chk("pop_valid", evt_valid_o, 1);
            chk("pop_order", evt_data_o, 32'hA5A5_0001 + i);
        end
        @(negedge clk);
        chk("drained_valid", evt_valid_o, 0);
        @(posedge clk); #1;
        ready = 0;
        rd_expect("status_drained", 8'h04, 32'h0001_0001);
        wr_expect("w1c", 8'h04, 32'h0001_0000, 4'hF, 0);
        rd_expect("status_w1c", 8'h04, 32'h0000_0001);

        wr_expect("push_bad_ben", 8'h08, 32'h1234_5678, 4'h3, 1);
        rd_expect("status_bad_ben", 8'h04, 32'h0000_0001);
        access(1'b0, 8'h1C, '0, 4'hF, ack, err, rd);
        chk("bad_off_err", err, 1);
        chk("bad_off_ack", ack, 0);
        wr_expect("ctrl_ben_ignored", 8'h00, 32'h0, 4'hE, 0);
        rd_expect("ctrl_kept", 8'h00, 32'h1);

        // Back-to-back reads
        stb = 1; rw = 0; addr = 8'h00;
        @(posedge clk); #1;
        addr = 8'h04;
        @(negedge clk);
        chk("b2b_ack0", bus_ack_o, 1);
        chk("b2b_data0", bus_data_o, 32'h1);
        @(posedge clk); #1;
        stb = 0;
        @(negedge clk);
        chk("b2b_ack1", bus_ack_o, 1);
        chk("b2b_data1", bus_data_o, 32'h1);
        @(posedge clk); #1;

        // Results and interrupt
        wr_expect("ctrl_irq", 8'h00, 32'h5, 4'hF, 0);
        res_valid = 1; res_data = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        res_valid = 0;
        @(posedge clk); #1;
        chk("irq_high", irq_o, 1);
        rd_expect("rescnt1", 8'h10, 32'h1);
        rd_expect("result1", 8'h0C, 32'hDEAD_BEEF);
        chk("irq_low", irq_o, 0);
        res_valid = 1; res_data = 32'h1111_0000;
        @(posedge clk); #1;
        res_valid = 0;
        @(posedge clk); #1;
        chk("irq_high2", irq_o, 1);
        stb = 1; rw = 0; addr = 8'h0C; res_valid = 1; res_data = 32'h2222_0000;
        @(posedge clk); #1;
        stb = 0; res_valid = 0;
        @(negedge clk);
        chk("race_old_data", bus_data_o, 32'h1111_0000);
        repeat (2) @(posedge clk);
        #1;
        chk("race_irq_held", irq_o, 1);
        rd_expect("result_race", 8'h0C, 32'h2222_0000);
        rd_expect("rescnt3", 8'h10, 32'h3);

        // Reset with queued events, active transfer and an in-flight access
        wr_expect("ctrl_off", 8'h00, 32'h0, 4'hF, 0);
        for (int i = 0; i < 3; i++) wr_expect("push3", 8'h08, 32'hC0DE_0000 + i, 4'hF, 0);
        wr_expect("ctrl_on", 8'h00, 32'h1, 4'hF, 0);
        ready = 1;
        @(posedge clk); #1;
        stb = 1; rw = 0; addr = 8'h04; rst = 1;
        @(posedge clk); #1;
        stb = 0;
        @(negedge clk);
        chk("rst_drop_ack", bus_ack_o, 0);
        chk("rst_drop_err", bus_err_o, 0);
        chk("rst_valid2", evt_valid_o, 0);
        @(posedge clk); #1;
        rst = 0; ready = 0;
        rd_expect("status_post_rst", 8'h04, 32'h0000_0001);
        rd_expect("rescnt_post_rst", 8'h10, 32'h0);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            logic [2:0] idx;
            rst = ($urandom_range(0, 299) == 0);
            stb = ($urandom_range(0, 9) < 7);
            rw = $urandom_range(0, 1);
            idx = ($urandom_range(0, 9) < 4) ? 3'd2 : 3'($urandom_range(0, 7));
            addr = {3'($urandom), idx, 2'($urandom)};
            wdata = $urandom;
            if (idx == 3'd0) wdata[1] = ($urandom_range(0, 7) == 0);
            ben = ($urandom_range(0, 3) != 0) ? 4'hF : 4'($urandom);
            ready = ($urandom_range(0, 2) == 0);
            res_valid = ($urandom_range(0, 4) == 0);
            res_data = $urandom;
            @(posedge clk); #1;
        end
        rst = 0; stb = 0; res_valid = 0; ready = 0;
        repeat (3) @(posedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
